// File: rtl/data_late_pkg.sv
// Shared constants and helpers for the data_late elastic pipeline.
// The optional Occupancy port is controlled by DATA_LATE_OCC_EN.
package data_late_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 1;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_late_stage.sv
// One valid+data slice of the elastic pipeline. Flush (clr) beats load for
// the valid bit, and the data register only changes on a load.
module data_late_stage
    import data_late_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             adv_out,
    output logic             vld,
    output logic [WIDTH-1:0] q
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state for the valid bit and the data word.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
        end else if (adv_out) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
        if (load) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Stage state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            vld_q  <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld = vld_q;
    assign q   = data_q;

endmodule

// File: rtl/data_late_pipe.sv
// Elastic DEPTH-stage data pipeline with stall, bubble collapse and flush.
// Defining DATA_LATE_OCC_EN adds the registered Occupancy output.
module data_late_pipe
    import data_late_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         Flush,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [WIDTH-1:0]             DataIn,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [WIDTH-1:0]             DataOut
`ifdef DATA_LATE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]  Occupancy
`endif
);

    logic [DEPTH-1:0] vld_s;
    logic [DEPTH-1:0] adv_s;
    logic [DEPTH-1:0] load_s;
    logic [WIDTH-1:0] q_s [DEPTH];
    logic [WIDTH-1:0] d_s [DEPTH];
    logic             in_xfer_s;

    // Advance chain runs from the output back to the input so bubbles collapse.
    always_comb begin
        adv_s            = {DEPTH{1'b0}};
        load_s           = {DEPTH{1'b0}};
        adv_s[DEPTH-1]   = vld_s[DEPTH-1] & OutReady;
        for (int s = DEPTH - 2; s >= 0; s--) begin
            adv_s[s] = vld_s[s] & (~vld_s[s+1] | adv_s[s+1]);
        end
        InReady   = ~Flush & (~vld_s[0] | adv_s[0]);
        in_xfer_s = InValid & InReady;
        load_s[0] = in_xfer_s;
        for (int s = 1; s < DEPTH; s++) begin
            load_s[s] = adv_s[s-1] & ~Flush;
        end
    end

    // Data feeding each stage: DataIn at the head, the previous stage elsewhere.
    always_comb begin
        d_s[0] = DataIn;
        for (int s = 1; s < DEPTH; s++) begin
            d_s[s] = q_s[s-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        data_late_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .CLK     (CLK),
            .Reset   (Reset),
            .load    (load_s[g]),
            .clr     (Flush),
            .d       (d_s[g]),
            .adv_out (adv_s[g]),
            .vld     (vld_s[g]),
            .q       (q_s[g])
        );
    end

    assign OutValid = vld_s[DEPTH-1];
    assign DataOut  = q_s[DEPTH-1];

`ifdef DATA_LATE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             out_xfer_s;

    // Occupancy follows input/output transfers; Flush wins over a same-cycle output.
    always_comb begin
        occ_d      = occ_q;
        out_xfer_s = OutValid & OutReady;
        if (Flush) begin
            occ_d = {OCC_W{1'b0}};
        end else if (in_xfer_s && !out_xfer_s) begin
            occ_d = occ_q + OCC_W'(1'b1);
        end else if (!in_xfer_s && out_xfer_s) begin
            occ_d = occ_q - OCC_W'(1'b1);
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            occ_q <= {OCC_W{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Occupancy = occ_q;
`endif

endmodule
